// File: rtl/id_ex_stage_reg_if.sv
// ID/EX pipeline register bus.
// Carries the decoded instruction from ID, the forwarding select/result
// signals, and the registered EX-stage outputs with the bubble counters.
//   master : ID-side driver (decoder, hazard unit, forwarding paths)
//   slave  : the ID/EX register itself
interface id_ex_stage_reg_if;
    // ID-stage instruction fields
    logic        id_valid;
    logic [5:0]  id_ins_type;
    logic [4:0]  id_rs;
    logic [4:0]  id_rt;
    logic [4:0]  id_wb_dest;
    logic        id_wb_en;
    logic [31:0] id_rs_val;
    logic [31:0] id_rt_val;
    logic [31:0] id_imm;
    logic [31:0] id_pc;

    // Operand forwarding: 0 = register file, 1 = EX result, 2 = MEM result
    logic [1:0]  mux_new_rsv;
    logic [1:0]  mux_new_rtv;
    logic [31:0] ex_alu_result;
    logic [31:0] mem_result;

    // Registered EX-stage outputs
    logic        ex_valid;
    logic [5:0]  ex_ins_type;
    logic [4:0]  ex_rs;
    logic [4:0]  ex_rt;
    logic [4:0]  ex_wb_dest;
    logic        ex_wb_en;
    logic [31:0] ex_rs_val;
    logic [31:0] ex_rt_val;
    logic [31:0] ex_imm;
    logic [31:0] ex_pc;

    // Bubble statistics
    logic [15:0] bubble_cnt;
    logic [15:0] flush_cnt;

    modport master (
        output id_valid, id_ins_type, id_rs, id_rt, id_wb_dest, id_wb_en,
               id_rs_val, id_rt_val, id_imm, id_pc,
               mux_new_rsv, mux_new_rtv, ex_alu_result, mem_result,
        input  ex_valid, ex_ins_type, ex_rs, ex_rt, ex_wb_dest, ex_wb_en,
               ex_rs_val, ex_rt_val, ex_imm, ex_pc,
               bubble_cnt, flush_cnt
    );

    modport slave (
        input  id_valid, id_ins_type, id_rs, id_rt, id_wb_dest, id_wb_en,
               id_rs_val, id_rt_val, id_imm, id_pc,
               mux_new_rsv, mux_new_rtv, ex_alu_result, mem_result,
        output ex_valid, ex_ins_type, ex_rs, ex_rt, ex_wb_dest, ex_wb_en,
               ex_rs_val, ex_rt_val, ex_imm, ex_pc,
               bubble_cnt, flush_cnt
    );
endinterface

// File: rtl/id_ex_stage_reg.sv
// ID/EX pipeline stage register.
// Latches the decoded ID instruction into EX with operand forwarding,
// injects NOP bubbles on stall/flush, and freezes entirely on hold.
// Edge priority: hold > flush > stall > load.
// Ports:
//   clk    : pipeline clock, rising edge
//   rst_n  : asynchronous active-low reset, clears everything to a bubble
//   stall  : load-use stall, inject bubble (counted in bubble_cnt)
//   flush  : taken branch/jump, inject bubble (counted in flush_cnt)
//   hold   : EX busy, freeze all state including counters
//   bus    : instruction/forwarding inputs and registered EX outputs
module id_ex_stage_reg (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               stall,
    input  logic               flush,
    input  logic               hold,
    id_ex_stage_reg_if.slave   bus
);

    typedef enum logic [1:0] {
        REG_VALUE_RF  = 2'd0,
        REG_VALUE_ALU = 2'd1,
        REG_VALUE_MEM = 2'd2
    } reg_value_sel_e;

    logic        ex_valid;
    logic [5:0]  ex_ins_type;
    logic [4:0]  ex_rs;
    logic [4:0]  ex_rt;
    logic [4:0]  ex_wb_dest;
    logic        ex_wb_en;
    logic [31:0] ex_rs_val;
    logic [31:0] ex_rt_val;
    logic [31:0] ex_imm;
    logic [31:0] ex_pc;
    logic [15:0] bubble_cnt;
    logic [15:0] flush_cnt;

    logic        do_load;
    logic        do_bubble;
    logic        inc_bubble;
    logic        inc_flush;
    logic [31:0] rs_val_sel;
    logic [31:0] rt_val_sel;

    // Register $zero always reads as 0, whatever the forwarding select says;
    // the reserved select falls back to the register-file value.
    function automatic logic [31:0] pick_operand(
        input logic [4:0]  reg_num,
        input logic [1:0]  sel,
        input logic [31:0] rf_val,
        input logic [31:0] alu_val,
        input logic [31:0] mem_val
    );
        logic [31:0] val;
        case (reg_value_sel_e'(sel))
            REG_VALUE_ALU: val = alu_val;
            REG_VALUE_MEM: val = mem_val;
            default:       val = rf_val;
        endcase
        if (reg_num == 5'd0) begin
            val = '0;
        end
        return val;
    endfunction

    always_comb begin
        // An invalid ID slot loads as a bubble but is not counted.
        do_load    = !hold && !flush && !stall && bus.id_valid;
        do_bubble  = !hold && !do_load;
        inc_flush  = !hold && flush;
        inc_bubble = !hold && !flush && stall;
        rs_val_sel = pick_operand(bus.id_rs, bus.mux_new_rsv, bus.id_rs_val,
                                  bus.ex_alu_result, bus.mem_result);
        rt_val_sel = pick_operand(bus.id_rt, bus.mux_new_rtv, bus.id_rt_val,
                                  bus.ex_alu_result, bus.mem_result);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_valid    <= 1'b0;
            ex_ins_type <= '0;
            ex_rs       <= '0;
            ex_rt       <= '0;
            ex_wb_dest  <= '0;
            ex_wb_en    <= 1'b0;
            ex_rs_val   <= '0;
            ex_rt_val   <= '0;
            ex_imm      <= '0;
            ex_pc       <= '0;
        end else if (do_load) begin
            ex_valid    <= 1'b1;
            ex_ins_type <= bus.id_ins_type;
            ex_rs       <= bus.id_rs;
            ex_rt       <= bus.id_rt;
            ex_wb_dest  <= bus.id_wb_dest;
            ex_wb_en    <= bus.id_wb_en;
            ex_rs_val   <= rs_val_sel;
            ex_rt_val   <= rt_val_sel;
            ex_imm      <= bus.id_imm;
            ex_pc       <= bus.id_pc;
        end else if (do_bubble) begin
            ex_valid    <= 1'b0;
            ex_ins_type <= '0;
            ex_rs       <= '0;
            ex_rt       <= '0;
            ex_wb_dest  <= '0;
            ex_wb_en    <= 1'b0;
            ex_rs_val   <= '0;
            ex_rt_val   <= '0;
            ex_imm      <= '0;
            ex_pc       <= '0;
        end
    end

    // Saturating bubble counters.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bubble_cnt <= '0;
            flush_cnt  <= '0;
        end else begin
            if (inc_bubble && (bubble_cnt != '1)) begin
                bubble_cnt <= bubble_cnt + 16'd1;
            end
            if (inc_flush && (flush_cnt != '1)) begin
                flush_cnt <= flush_cnt + 16'd1;
            end
        end
    end

    assign bus.ex_valid    = ex_valid;
    assign bus.ex_ins_type = ex_ins_type;
    assign bus.ex_rs       = ex_rs;
    assign bus.ex_rt       = ex_rt;
    assign bus.ex_wb_dest  = ex_wb_dest;
    assign bus.ex_wb_en    = ex_wb_en;
    assign bus.ex_rs_val   = ex_rs_val;
    assign bus.ex_rt_val   = ex_rt_val;
    assign bus.ex_imm      = ex_imm;
    assign bus.ex_pc       = ex_pc;
    assign bus.bubble_cnt  = bubble_cnt;
    assign bus.flush_cnt   = flush_cnt;

endmodule

// File: tb/tb_id_ex_stage_reg.sv
// Directed self-checking bench for id_ex_stage_reg.
module tb_id_ex_stage_reg;

    logic clk;
    logic rst_n;
    logic stall;
    logic flush;
    logic hold;

    int unsigned total;
    int unsigned bad;

    id_ex_stage_reg_if bus ();

    id_ex_stage_reg dut (
        .clk   (clk),
        .rst_n (rst_n),
        .stall (stall),
        .flush (flush),
        .hold  (hold),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=0x%08h expected=0x%08h", tag, got, exp);
        end
    endtask

    // Advance one rising edge and settle just after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_instr(input logic valid, input logic [5:0] ins_type,
                               input logic [4:0] rs, input logic [4:0] rt,
                               input logic [4:0] wb_dest, input logic wb_en,
                               input logic [31:0] rs_val, input logic [31:0] rt_val,
                               input logic [31:0] imm, input logic [31:0] pc);
        bus.id_valid    = valid;
        bus.id_ins_type = ins_type;
        bus.id_rs       = rs;
        bus.id_rt       = rt;
        bus.id_wb_dest  = wb_dest;
        bus.id_wb_en    = wb_en;
        bus.id_rs_val   = rs_val;
        bus.id_rt_val   = rt_val;
        bus.id_imm      = imm;
        bus.id_pc       = pc;
    endtask

    task automatic check_bubble(input string tag);
        check({tag, ".valid"},   {31'd0, bus.ex_valid},   32'd0);
        check({tag, ".type"},    {26'd0, bus.ex_ins_type}, 32'd0);
        check({tag, ".wb_en"},   {31'd0, bus.ex_wb_en},   32'd0);
        check({tag, ".wb_dest"}, {27'd0, bus.ex_wb_dest}, 32'd0);
        check({tag, ".rs"},      {27'd0, bus.ex_rs},      32'd0);
        check({tag, ".rt"},      {27'd0, bus.ex_rt},      32'd0);
        check({tag, ".rs_val"},  bus.ex_rs_val,           32'd0);
        check({tag, ".rt_val"},  bus.ex_rt_val,           32'd0);
        check({tag, ".imm"},     bus.ex_imm,              32'd0);
        check({tag, ".pc"},      bus.ex_pc,               32'd0);
    endtask

    initial begin
        total = 0;
        bad   = 0;
        rst_n = 1'b0;
        stall = 1'b0;
        flush = 1'b0;
        hold  = 1'b0;
        bus.mux_new_rsv   = 2'd0;
        bus.mux_new_rtv   = 2'd0;
        bus.ex_alu_result = 32'hAAAA0000;
        bus.mem_result    = 32'h00005555;
        drive_instr(1'b1, 6'd5, 5'd3, 5'd4, 5'd7, 1'b1,
                    32'h11, 32'h22, 32'h1234, 32'h400);

        // Reset state, before any clock edge
        #2;
        check_bubble("reset");
        check("reset.bubble_cnt", {16'd0, bus.bubble_cnt}, 32'd0);
        check("reset.flush_cnt",  {16'd0, bus.flush_cnt},  32'd0);
        #10;
        rst_n = 1'b1;

        // Plain load
        tick();
        check("load.valid",   {31'd0, bus.ex_valid},    32'd1);
        check("load.type",    {26'd0, bus.ex_ins_type}, 32'd5);
        check("load.rs",      {27'd0, bus.ex_rs},       32'd3);
        check("load.rt",      {27'd0, bus.ex_rt},       32'd4);
        check("load.wb_dest", {27'd0, bus.ex_wb_dest},  32'd7);
        check("load.wb_en",   {31'd0, bus.ex_wb_en},    32'd1);
        check("load.rs_val",  bus.ex_rs_val,            32'h11);
        check("load.rt_val",  bus.ex_rt_val,            32'h22);
        check("load.imm",     bus.ex_imm,               32'h1234);
        check("load.pc",      bus.ex_pc,                32'h400);

        // Forwarding from EX and MEM
        bus.mux_new_rsv = 2'd1;
        bus.mux_new_rtv = 2'd2;
        tick();
        check("fwd.rs_val", bus.ex_rs_val, 32'hAAAA0000);
        check("fwd.rt_val", bus.ex_rt_val, 32'h00005555);

        // $zero source overrides forwarding
        bus.id_rs = 5'd0;
        tick();
        check("fwd_zero.rs_val", bus.ex_rs_val, 32'd0);
        check("fwd_zero.rt_val", bus.ex_rt_val, 32'h00005555);

        // Reserved select reads the register file; rt=0 zeroes rt_val
        bus.id_rs       = 5'd9;
        bus.id_rt       = 5'd0;
        bus.mux_new_rsv = 2'd3;
        tick();
        check("sel3.rs_val",  bus.ex_rs_val, 32'h11);
        check("rt_zero.rt_val", bus.ex_rt_val, 32'd0);

        // Three stall cycles, then release
        bus.mux_new_rsv = 2'd0;
        bus.mux_new_rtv = 2'd0;
        drive_instr(1'b1, 6'd12, 5'd1, 5'd2, 5'd8, 1'b1,
                    32'h33, 32'h44, 32'h10, 32'h500);
        stall = 1'b1;
        for (int unsigned i = 1; i <= 3; i++) begin
            tick();
            check_bubble("stall");
            check("stall.bubble_cnt", {16'd0, bus.bubble_cnt}, i);
        end
        stall = 1'b0;
        tick();
        check("after_stall.valid",  {31'd0, bus.ex_valid},    32'd1);
        check("after_stall.type",   {26'd0, bus.ex_ins_type}, 32'd12);
        check("after_stall.rs_val", bus.ex_rs_val,            32'h33);
        check("after_stall.pc",     bus.ex_pc,                32'h500);

        // Stall and flush together: counted as flush only
        stall = 1'b1;
        flush = 1'b1;
        tick();
        check_bubble("stall_flush");
        check("stall_flush.flush_cnt",  {16'd0, bus.flush_cnt},  32'd1);
        check("stall_flush.bubble_cnt", {16'd0, bus.bubble_cnt}, 32'd3);
        stall = 1'b0;
        tick();
        check("flush.flush_cnt",  {16'd0, bus.flush_cnt},  32'd2);
        check("flush.bubble_cnt", {16'd0, bus.bubble_cnt}, 32'd3);
        flush = 1'b0;

        // Reload, then hold with stall and changed inputs: nothing moves
        tick();
        check("reload.valid", {31'd0, bus.ex_valid}, 32'd1);
        hold  = 1'b1;
        stall = 1'b1;
        flush = 1'b1;
        drive_instr(1'b1, 6'd3, 5'd5, 5'd6, 5'd9, 1'b0,
                    32'h77, 32'h88, 32'h99, 32'h600);
        tick();
        tick();
        check("hold.valid",      {31'd0, bus.ex_valid},    32'd1);
        check("hold.type",       {26'd0, bus.ex_ins_type}, 32'd12);
        check("hold.wb_dest",    {27'd0, bus.ex_wb_dest},  32'd8);
        check("hold.rs_val",     bus.ex_rs_val,            32'h33);
        check("hold.pc",         bus.ex_pc,                32'h500);
        check("hold.bubble_cnt", {16'd0, bus.bubble_cnt},  32'd3);
        check("hold.flush_cnt",  {16'd0, bus.flush_cnt},   32'd2);
        stall = 1'b0;
        flush = 1'b0;

        // Reset mid-hold, asynchronous, between edges
        #1;
        rst_n = 1'b0;
        #1;
        check_bubble("async_rst");
        check("async_rst.bubble_cnt", {16'd0, bus.bubble_cnt}, 32'd0);
        check("async_rst.flush_cnt",  {16'd0, bus.flush_cnt},  32'd0);
        #1;
        rst_n = 1'b1;
        hold  = 1'b0;
        tick();
        check("post_rst.valid", {31'd0, bus.ex_valid},    32'd1);
        check("post_rst.type",  {26'd0, bus.ex_ins_type}, 32'd3);
        check("post_rst.rt",    {27'd0, bus.ex_rt},       32'd6);

        // Invalid ID slot loads as an uncounted bubble
        bus.id_valid = 1'b0;
        tick();
        check_bubble("invalid");
        check("invalid.bubble_cnt", {16'd0, bus.bubble_cnt}, 32'd0);
        check("invalid.flush_cnt",  {16'd0, bus.flush_cnt},  32'd0);

        // Drive bubble_cnt to 16'hFFFE, then 3 more stalls saturate
        stall = 1'b1;
        for (int unsigned i = 0; i < 32'd65534; i++) begin
            @(posedge clk);
        end
        #1;
        check("sat.preload", {16'd0, bus.bubble_cnt}, 32'h0000FFFE);
        for (int unsigned i = 0; i < 3; i++) begin
            tick();
        end
        check("sat.bubble_cnt", {16'd0, bus.bubble_cnt}, 32'h0000FFFF);
        check("sat.flush_cnt",  {16'd0, bus.flush_cnt},  32'd0);

        // Reset pulse between edges, mid-stall
        #1;
        rst_n = 1'b0;
        #1;
        check_bubble("rst_pulse");
        check("rst_pulse.bubble_cnt", {16'd0, bus.bubble_cnt}, 32'd0);
        #1;
        rst_n = 1'b1;
        stall = 1'b0;
        bus.id_valid = 1'b1;
        tick();
        check("final_load.valid", {31'd0, bus.ex_valid}, 32'd1);
        check("final_load.bubble_cnt", {16'd0, bus.bubble_cnt}, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
